tls_monitor: RTL and testbench
==============================

# tls_monitor

Observer for the traffic-light controller's lamp outputs. Samples the three lamp lines every clock, decodes the current phase, and measures how many cycles each colour was lit. It reports a completed-cycle pulse, a forced-red (jump) pulse and sticky protocol-error flags. It sits on the receive side of the lamp interface, for example in a checker or a roadside status unit, and has no control path back to the controller.

## Interface
- MAXLEN, default 12: phase-length threshold for the watchdog. Legal range 1..14.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces every register and output to its reset value.
- Gl  in  1  green lamp, synchronous to clk.
- Yl  in  1  yellow lamp, synchronous to clk.
- Rl  in  1  red lamp, synchronous to clk.
- clr  in  1  synchronous clear of the length registers and of all sticky flags.
- Phase  out  2  registered decoded phase: 00 dark, 01 green, 10 yellow, 11 red.
- Glen  out  4  length in cycles of the last completed green phase.
- Ylen  out  4  length in cycles of the last completed yellow phase.
- Rlen  out  4  length in cycles of the last completed red phase.
- Done  out  1  one-cycle pulse when a full G→Y→R cycle completes.
- JumpDet  out  1  one-cycle pulse on a forced entry into red (G→R or dark→R).
- SeqErr  out  1  sticky: an illegal phase transition was seen.
- MultiErr  out  1  sticky: more than one lamp was lit in the same cycle.
- Timeout  out  1  sticky watchdog flag; exists only when TLS_MON_WDOG_EN is defined.

## Operation
- Input decode, every cycle:
  - No lamp lit gives dark; exactly one lamp lit gives that colour.
  - Two or more lamps lit: MultiErr is set, the decoded value is treated as "no change", and the counter keeps running.
- Internal state:
  - Phase register (holds the previous decoded phase).
  - 4-bit saturating counter Cnt (stops at 15).
  - Cycle-tracking state: Idle, SawG, SawGY, SawGYR.
- Phase change (decoded value differs from Phase):
  - The length register of the colour being left is loaded with Cnt. Leaving dark loads nothing.
  - Cnt is set to 1 and Phase is set to the new value.
- No phase change: Cnt increments, saturating at 15.
- Legal transitions:
  - dark→G
  - G→Y
  - Y→R
  - R→G
  - G→R and dark→R: legal but pulse JumpDet.
  - any→dark: models a controller reset.
- Illegal transitions: Y→G, R→Y, dark→Y. Each sets SeqErr; the new phase is still adopted.
- Cycle tracking:
  - Entering G sets SawG.
  - G→Y goes to SawGY.
  - SawGY with Y→R goes to SawGYR.
  - SawGYR with R→G pulses Done and goes to SawG.
  - A jump, an illegal transition, or entering dark returns to Idle. Entering G after an illegal transition gives SawG.
- clr: zeroes Glen/Ylen/Rlen, SeqErr, MultiErr and Timeout. It does not affect Phase, Cnt or cycle tracking.
- Priority: reset > error set in the same cycle > clr. A flag being set wins over a simultaneous clr.

## Timing
- Reset values: Phase=00, Glen=Ylen=Rlen=0, Cnt=0, tracking=Idle, and Done, JumpDet, SeqErr, MultiErr, Timeout all 0.
- Latency: a lamp change at cycle n appears on Phase after edge n. The length register, Done, JumpDet and SeqErr update on the same edge.
- A lamp lit for k consecutive sampled cycles reports length k, or 15 if k ≥ 15.
- Done and JumpDet are high for exactly one cycle per event.
- Reset asserted mid-phase: the measurement in progress is discarded. After release the block starts from dark/Idle.
- A one-cycle glitch of a single lamp is treated as a phase of length 1.

## Configuration
- Macro TLS_MON_WDOG_EN.
- Defined:
  - Timeout port and logic are present.
  - Timeout is set on the edge where a non-dark phase is continuing and Cnt already equals MAXLEN, i.e. the phase is on its (MAXLEN+1)-th cycle.
  - Timeout is sticky until clr or reset.
- Not defined: no Timeout port, no comparator; all other behaviour is identical.

## Test plan
- Green 3 cycles, yellow 2, red 4, then green → Glen=3, Ylen=2, Rlen=4; Done pulses one cycle, on the edge where green is sampled again; no flags set.
- Green 2 cycles, then red (jump) for 3 cycles → JumpDet pulses at entry to red; Glen=2; no Done at the next R→G; SeqErr=0.
- Yellow followed directly by green → SeqErr=1 and stays 1; pulse clr → SeqErr=0.
- Gl and Rl both high for 1 cycle during a green phase → MultiErr=1 and Phase stays 01; the eventual green length includes that cycle.
- Red held for 20 cycles → Rlen=15 (saturated). With TLS_MON_WDOG_EN and MAXLEN=12, Timeout rises on the 13th red cycle.
- Reset asserted in the middle of a yellow phase → all outputs 0 immediately. After release, dark→G→Y→R→G gives Done with fresh lengths.

Source files
------------

// File: rtl/tls_monitor.sv
// tls_monitor: passive observer of the traffic-light lamp lines.
// Decodes the lamp phase and measures the length of each colour.
// It also flags completed cycles, forced reds and protocol errors.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   Gl, Yl, Rl     lamp lines, synchronous to clk
//   clr            synchronous clear of the lengths and sticky flags
//   Phase          registered phase: 00 dark, 01 G, 10 Y, 11 R
//   Glen/Ylen/Rlen length of the last completed phase of each colour
//   Done           one-cycle pulse when a full G->Y->R->G cycle ends
//   JumpDet        one-cycle pulse on G->R or dark->R
//   SeqErr         sticky flag: illegal transition seen
//   MultiErr       sticky flag: more than one lamp lit
//   Timeout        sticky watchdog flag (only with TLS_MON_WDOG_EN)
//
// Optional feature macro: TLS_MON_WDOG_EN adds the Timeout watchdog.
// MAXLEN (1..14) is the watchdog phase-length threshold.

module tls_monitor #(
    parameter int MAXLEN = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Gl,
    input  logic       Yl,
    input  logic       Rl,
    input  logic       clr,
    output logic [1:0] Phase,
    output logic [3:0] Glen,
    output logic [3:0] Ylen,
    output logic [3:0] Rlen,
    output logic       Done,
    output logic       JumpDet,
    output logic       SeqErr,
    output logic       MultiErr
`ifdef TLS_MON_WDOG_EN
    ,
    output logic       Timeout
`endif
);

    if (MAXLEN < 1 || MAXLEN > 14) begin : g_bad_maxlen
        $error("tls_monitor: MAXLEN must be in 1..14");
    end

    typedef enum logic [1:0] {
        P_DARK = 2'b00,
        P_G    = 2'b01,
        P_Y    = 2'b10,
        P_R    = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SAWG,
        T_SAWGY,
        T_SAWGYR
    } trk_t;

    phase_t     ph;
    phase_t     dec;
    trk_t       trk;
    trk_t       trk_nxt;
    logic [3:0] cnt;
    logic       multi;
    logic       chg;
    logic       illegal;
    logic       jump;
    logic       done_nxt;

    assign Phase = ph;

    // Two or more lamps lit at once.
    assign multi = (Gl & Yl) | (Gl & Rl) | (Yl & Rl);

    // A multi-lamp cycle decodes as "no change", so the running
    // phase keeps counting through it.
    always_comb begin
        dec = ph;
        if (!multi) begin
            unique case (1'b1)
                Gl:      dec = P_G;
                Yl:      dec = P_Y;
                Rl:      dec = P_R;
                default: dec = P_DARK;
            endcase
        end
    end

    assign chg = (dec != ph);

    assign illegal = chg &&
        ((ph == P_Y    && dec == P_G) ||
         (ph == P_R    && dec == P_Y) ||
         (ph == P_DARK && dec == P_Y));

    assign jump = chg && (dec == P_R) &&
        (ph == P_G || ph == P_DARK);

    // Cycle tracking: only a clean G->Y->R->G sequence completes.
    // Every entry into G restarts tracking at SawG, including the
    // illegal Y->G.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk <= T_IDLE;
        end else begin
            trk <= trk_nxt;
        end
    end

    always_comb begin
        trk_nxt  = trk;
        done_nxt = 1'b0;
        if (chg) begin
            unique case (dec)
                P_G: begin
                    trk_nxt  = T_SAWG;
                    done_nxt = (trk == T_SAWGYR) && (ph == P_R);
                end
                P_Y: begin
                    if (ph == P_G && trk == T_SAWG) begin
                        trk_nxt = T_SAWGY;
                    end else begin
                        trk_nxt = T_IDLE;
                    end
                end
                P_R: begin
                    if (ph == P_Y && trk == T_SAWGY) begin
                        trk_nxt = T_SAWGYR;
                    end else begin
                        trk_nxt = T_IDLE;
                    end
                end
                default: trk_nxt = T_IDLE;
            endcase
        end
    end

    // Phase register and saturating length counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph  <= P_DARK;
            cnt <= 4'd0;
        end else begin
            ph <= dec;
            if (chg) begin
                cnt <= 4'd1;
            end else if (cnt != 4'd15) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Length registers: a phase completing in the same cycle as clr
    // still reports its length, so no measurement is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Glen <= 4'd0;
            Ylen <= 4'd0;
            Rlen <= 4'd0;
        end else begin
            if (chg && ph == P_G) begin
                Glen <= cnt;
            end else if (clr) begin
                Glen <= 4'd0;
            end
            if (chg && ph == P_Y) begin
                Ylen <= cnt;
            end else if (clr) begin
                Ylen <= 4'd0;
            end
            if (chg && ph == P_R) begin
                Rlen <= cnt;
            end else if (clr) begin
                Rlen <= 4'd0;
            end
        end
    end

    // Event pulses and sticky flags; a flag being set beats clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Done     <= 1'b0;
            JumpDet  <= 1'b0;
            SeqErr   <= 1'b0;
            MultiErr <= 1'b0;
        end else begin
            Done     <= done_nxt;
            JumpDet  <= jump;
            SeqErr   <= illegal | (SeqErr & ~clr);
            MultiErr <= multi | (MultiErr & ~clr);
        end
    end

`ifdef TLS_MON_WDOG_EN
    localparam logic [3:0] MAX4 = 4'(MAXLEN);

    // Fires on the (MAXLEN+1)-th cycle of a continuing lit phase.
    logic to_hit;
    assign to_hit = !chg && (ph != P_DARK) && (cnt == MAX4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Timeout <= 1'b0;
        end else begin
            Timeout <= to_hit | (Timeout & ~clr);
        end
    end
`endif

endmodule

// File: tb/tb_tls_monitor.sv
// tb_tls_monitor: scoreboard bench for tls_monitor.
// Expectations are queued per driven cycle and checked after the edge.

module tb_tls_monitor;

    localparam int F_PH   = 0;
    localparam int F_G    = 1;
    localparam int F_Y    = 2;
    localparam int F_R    = 3;
    localparam int F_DONE = 4;
    localparam int F_JMP  = 5;
    localparam int F_SEQ  = 6;
    localparam int F_MUL  = 7;
    localparam int F_TO   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       Gl, Yl, Rl, clr;
    logic [1:0] Phase;
    logic [3:0] Glen, Ylen, Rlen;
    logic       Done, JumpDet, SeqErr, MultiErr;
`ifdef TLS_MON_WDOG_EN
    logic       Timeout;
`endif

    tls_monitor #(.MAXLEN(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .Gl       (Gl),
        .Yl       (Yl),
        .Rl       (Rl),
        .clr      (clr),
        .Phase    (Phase),
        .Glen     (Glen),
        .Ylen     (Ylen),
        .Rlen     (Rlen),
        .Done     (Done),
        .JumpDet  (JumpDet),
        .SeqErr   (SeqErr),
        .MultiErr (MultiErr)
`ifdef TLS_MON_WDOG_EN
        ,
        .Timeout  (Timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string tag;
        int    fld;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    int   drv_cyc  = 0;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int field(input int f);
        case (f)
            F_PH:    return int'(Phase);
            F_G:     return int'(Glen);
            F_Y:     return int'(Ylen);
            F_R:     return int'(Rlen);
            F_DONE:  return int'(Done);
            F_JMP:   return int'(JumpDet);
            F_SEQ:   return int'(SeqErr);
            F_MUL:   return int'(MultiErr);
`ifdef TLS_MON_WDOG_EN
            F_TO:    return int'(Timeout);
`endif
            default: return -1;
        endcase
    endfunction

    // Output side of the scoreboard: pop everything due at this edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        edge_cnt++;
        while (sbq.size() > 0 && sbq[0].cyc <= edge_cnt) begin
            e = sbq.pop_front();
            check(e.tag, field(e.fld), e.val);
        end
    end

    task automatic drive(input logic g, input logic y, input logic r,
                         input logic c = 1'b0);
        @(negedge clk);
        Gl = g;
        Yl = y;
        Rl = r;
        clr = c;
        drv_cyc = edge_cnt + 1;
    endtask

    task automatic want(input string tag, input int f, input int v);
        exp_t e;
        e.cyc = drv_cyc;
        e.tag = tag;
        e.fld = f;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic all_zero(input string pfx);
        check({pfx, "_ph"},   int'(Phase),    0);
        check({pfx, "_glen"}, int'(Glen),     0);
        check({pfx, "_ylen"}, int'(Ylen),     0);
        check({pfx, "_rlen"}, int'(Rlen),     0);
        check({pfx, "_done"}, int'(Done),     0);
        check({pfx, "_jmp"},  int'(JumpDet),  0);
        check({pfx, "_seq"},  int'(SeqErr),   0);
        check({pfx, "_mul"},  int'(MultiErr), 0);
`ifdef TLS_MON_WDOG_EN
        check({pfx, "_to"},   int'(Timeout),  0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        Gl = 1'b0;
        Yl = 1'b0;
        Rl = 1'b0;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        all_zero("rst");
        reset = 1'b0;

        // Full cycle G3 Y2 R4 G.
        drive(1, 0, 0);
        want("t1_ph_g", F_PH, 1);
        want("t1_jmp0", F_JMP, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 1, 0);
        want("t1_glen", F_G, 3);
        want("t1_ph_y", F_PH, 2);
        drive(0, 1, 0);
        drive(0, 0, 1);
        want("t1_ylen", F_Y, 2);
        want("t1_done_early", F_DONE, 0);
        repeat (3) drive(0, 0, 1);
        drive(1, 0, 0);
        want("t1_rlen", F_R, 4);
        want("t1_done", F_DONE, 1);
        drive(1, 0, 0);
        want("t1_done_off", F_DONE, 0);
        want("t1_seq", F_SEQ, 0);
        want("t1_mul", F_MUL, 0);

        // Jump G->R after 2 green cycles.
        drive(0, 0, 1);
        want("t2_jmp", F_JMP, 1);
        want("t2_glen", F_G, 2);
        drive(0, 0, 1);
        want("t2_jmp_off", F_JMP, 0);
        drive(0, 0, 1);
        drive(1, 0, 0);
        want("t2_rlen", F_R, 3);
        want("t2_no_done", F_DONE, 0);
        want("t2_seq", F_SEQ, 0);

        // Illegal Y->G, sticky SeqErr, then clr.
        drive(0, 1, 0);
        want("t3_glen", F_G, 1);
        drive(1, 0, 0);
        want("t3_seq", F_SEQ, 1);
        want("t3_ylen", F_Y, 1);
        drive(1, 0, 0);
        want("t3_seq_sticky", F_SEQ, 1);
        drive(1, 0, 0, 1);
        want("t3_seq_clr", F_SEQ, 0);
        want("t3_ylen_clr", F_Y, 0);
        want("t3_rlen_clr", F_R, 0);
        want("t3_glen_clr", F_G, 0);

        // Multi-lamp cycles inside green; set beats clr.
        drive(1, 0, 1);
        want("t4_mul", F_MUL, 1);
        want("t4_ph", F_PH, 1);
        drive(1, 1, 0, 1);
        want("t4_mul_vs_clr", F_MUL, 1);
        want("t4_ph2", F_PH, 1);
        drive(1, 0, 0);
        drive(0, 1, 0);
        want("t4_glen", F_G, 6);
        want("t4_mul_sticky", F_MUL, 1);

        // Long red: saturation and watchdog.
        for (int i = 1; i <= 20; i++) begin
            drive(0, 0, 1);
            if (i == 1) want("t5_ylen", F_Y, 1);
`ifdef TLS_MON_WDOG_EN
            if (i == 12) want("t5_to_early", F_TO, 0);
            if (i == 13) want("t5_to", F_TO, 1);
`endif
        end
        drive(1, 0, 0);
        want("t5_rlen_sat", F_R, 15);
        want("t5_done", F_DONE, 1);

        // Reset in the middle of a yellow phase.
        drive(0, 1, 0);
        drive(0, 1, 0);
        want("t6_ph_y", F_PH, 2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        Gl = 1'b0;
        Yl = 1'b0;
        Rl = 1'b0;
        #1;
        all_zero("t6_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0);
        want("t6_ph_dark", F_PH, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 1, 0);
        want("t6_glen", F_G, 2);
        want("t6_ylen_fresh", F_Y, 0);
        repeat (2) drive(0, 1, 0);
        drive(0, 0, 1);
        want("t6_ylen", F_Y, 3);
        want("t6_jmp", F_JMP, 0);
        drive(1, 0, 0);
        want("t6_rlen", F_R, 1);
        want("t6_done", F_DONE, 1);

        // dark->Y is illegal, dark->R is a jump.
        drive(0, 0, 0);
        want("t7_ph_dark", F_PH, 0);
        drive(0, 1, 0);
        want("t7_seq", F_SEQ, 1);
        drive(0, 0, 0);
        drive(0, 0, 1);
        want("t8_jmp", F_JMP, 1);
        want("t8_ph_r", F_PH, 3);
        drive(0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
